// File: rtl/data_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// data_reg_bank_pkg
// Shared definitions for consumers of the 4-entry 32-bit data register bank.
//   DATA_W / NUM_REGS / ADDR_W : bank geometry
//   CNT_W                      : width of a beat counter able to hold NUM_REGS
//   drb_state_e                : reader FSM encoding (IDLE / SEND / DONE)
//   decode_run_len()           : run length decode, 0 encodes a full NUM_REGS run
// -----------------------------------------------------------------------------
package data_reg_bank_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;
  localparam int CNT_W    = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drb_state_e;

  // A zero length field means a full pass over the bank.
  function automatic logic [CNT_W-1:0] decode_run_len(input logic [ADDR_W-1:0] len);
    logic [CNT_W-1:0] cnt;
    if (len == {ADDR_W{1'b0}}) begin
      cnt = CNT_W'(NUM_REGS);
    end else begin
      cnt = {1'b0, len};
    end
    return cnt;
  endfunction

endpackage : data_reg_bank_pkg

// File: rtl/drb_read_mux.sv
// -----------------------------------------------------------------------------
// drb_read_mux
// Combinational NUM_REGS:1 selector over a flattened bank image.
// Entry i occupies bits [i*DATA_W +: DATA_W] of data_flat_i.
// Ports:
//   data_flat_i : NUM_REGS*DATA_W  flattened bank entries (live or snapshot)
//   sel_i       : ADDR_W           entry index
//   data_o      : DATA_W           selected entry
// -----------------------------------------------------------------------------
module drb_read_mux #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic [NUM_REGS*DATA_W-1:0] data_flat_i,
  input  logic [ADDR_W-1:0]          sel_i,
  output logic [DATA_W-1:0]          data_o
);

  assign data_o = data_flat_i[int'(sel_i)*DATA_W +: DATA_W];

endmodule : drb_read_mux

// File: rtl/data_reg_bank_reader.sv
// -----------------------------------------------------------------------------
// data_reg_bank_reader
// Streams a contiguous, wrapping run of data register bank entries onto a
// valid/ready interface, one entry per beat, flags the final beat and pulses
// done once the run has been fully accepted.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   bank_in0..bank_in3    : parallel bank entries
//   start                 : run request, honoured only in IDLE
//   start_addr            : first entry of the run
//   run_len               : beat count, 0 encodes NUM_REGS
//   dout, dout_addr       : current beat data and its bank index
//   dout_valid/dout_ready : stream handshake
//   dout_last             : current beat is the last of the run
//   busy                  : run in progress (SEND or DONE)
//   done                  : one-cycle pulse after the last beat transfers
//
// Build option DRB_READER_SNAPSHOT_EN: when defined, the whole bank is
// captured when a run is accepted and every beat is served from that copy.
// When undefined, the pending beat is re-registered from the live bank each
// stall cycle, so a bank write during a stall is reflected on dout.
// -----------------------------------------------------------------------------
module data_reg_bank_reader
  import data_reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bank_in0,
  input  logic [DATA_W-1:0] bank_in1,
  input  logic [DATA_W-1:0] bank_in2,
  input  logic [DATA_W-1:0] bank_in3,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] run_len,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  drb_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           rem_q, rem_d;
  logic [DATA_W-1:0]          dout_q, dout_d;
  logic [ADDR_W-1:0]          dout_addr_q, dout_addr_d;
  logic                       dout_valid_q, dout_valid_d;
  logic                       dout_last_q, dout_last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [NUM_REGS*DATA_W-1:0] live_flat_s;
  logic [NUM_REGS*DATA_W-1:0] mux_src_s;
  logic [ADDR_W-1:0]          ptr_inc_s;
  logic [ADDR_W-1:0]          sel_ptr_s;
  logic [DATA_W-1:0]          mux_data_s;
  logic [CNT_W-1:0]           len_dec_s;
  logic                       xfer_s;

  assign live_flat_s = {bank_in3, bank_in2, bank_in1, bank_in0};
  assign xfer_s      = dout_valid_q & dout_ready;
  // ADDR_W-bit add wraps NUM_REGS-1 back to 0 because NUM_REGS is a power of two.
  assign ptr_inc_s   = rd_ptr_q + ADDR_W'(1);
  assign len_dec_s   = decode_run_len(run_len);

  // Entry that will be on dout after the next edge: the first entry when a
  // run starts, the next entry on a transfer, the same entry while stalled.
  assign sel_ptr_s = (state_q == IDLE) ? start_addr :
                     (xfer_s ? ptr_inc_s : rd_ptr_q);

`ifdef DRB_READER_SNAPSHOT_EN
  logic [NUM_REGS*DATA_W-1:0] snap_q, snap_d;

  // Snapshot next-state: capture the whole bank when a run is accepted.
  always_comb begin
    if ((state_q == IDLE) && start) begin
      snap_d = live_flat_s;
    end else begin
      snap_d = snap_q;
    end
  end

  // Snapshot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= {(NUM_REGS*DATA_W){1'b0}};
    end else begin
      snap_q <= snap_d;
    end
  end

  // First beat comes from the live bank (snapshot loads on the same edge),
  // every later beat from the snapshot.
  assign mux_src_s = (state_q == IDLE) ? live_flat_s : snap_q;
`else
  assign mux_src_s = live_flat_s;
`endif

  drb_read_mux #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_read_mux (
    .data_flat_i (mux_src_s),
    .sel_i       (sel_ptr_s),
    .data_o      (mux_data_s)
  );

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    rem_d        = rem_q;
    dout_d       = dout_q;
    dout_addr_d  = dout_addr_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d     = start_addr;
          rem_d        = len_dec_s;
          dout_d       = mux_data_s;
          dout_addr_d  = start_addr;
          dout_last_d  = (len_dec_s == CNT_W'(1));
          dout_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (xfer_s) begin
          rd_ptr_d = ptr_inc_s;
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            done_d       = 1'b1;
            state_d      = DONE;
          end else begin
            dout_d      = mux_data_s;
            dout_addr_d = ptr_inc_s;
            dout_last_d = (rem_q == CNT_W'(2));
          end
        end else begin
          // Stall: re-register the pending entry (live or snapshot source).
          dout_d = mux_data_s;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_ptr_q     <= {ADDR_W{1'b0}};
      rem_q        <= {CNT_W{1'b0}};
      dout_q       <= {DATA_W{1'b0}};
      dout_addr_q  <= {ADDR_W{1'b0}};
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      rem_q        <= rem_d;
      dout_q       <= dout_d;
      dout_addr_q  <= dout_addr_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_addr  = dout_addr_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : data_reg_bank_reader

// File: tb/tb_data_reg_bank_reader.sv
// -----------------------------------------------------------------------------
// tb_data_reg_bank_reader
// Directed bench for data_reg_bank_reader. Expected beats are queued when a
// run is started and compared by a monitor whenever a beat transfers.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_data_reg_bank_reader;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  a;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bank_in0, bank_in1, bank_in2, bank_in3;
  logic        start;
  logic [1:0]  start_addr;
  logic [1:0]  run_len;
  logic [31:0] dout;
  logic [1:0]  dout_addr;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  logic        done;

  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  beat_t       exp_q[$];
  logic [31:0] bank_m [4];
  logic        stab_en = 1'b1;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_dout = 32'd0;
  logic [1:0]  prev_addr = 2'd0;
  logic        prev_last = 1'b0;

  data_reg_bank_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank_in0   (bank_in0),
    .bank_in1   (bank_in1),
    .bank_in2   (bank_in2),
    .bank_in3   (bank_in3),
    .start      (start),
    .start_addr (start_addr),
    .run_len    (run_len),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] b2, input logic [31:0] b3);
    bank_m[0] = b0; bank_m[1] = b1; bank_m[2] = b2; bank_m[3] = b3;
    bank_in0 = b0;  bank_in1 = b1;  bank_in2 = b2;  bank_in3 = b3;
  endtask

  // Pulse start for one cycle and queue the beats the run should produce.
  task automatic run_start(input logic [1:0] addr, input logic [1:0] len);
    int    n;
    logic [1:0] a;
    beat_t b;
    n = (len == 2'd0) ? 4 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = addr + 2'(i);
      b.d = bank_m[a];
      b.a = a;
      b.l = (i == n - 1);
      exp_q.push_back(b);
    end
    done_base  = done_cnt;
    start      = 1'b1;
    start_addr = addr;
    run_len    = len;
    step();
    start = 1'b0;
    check("first_valid_latency", dout_valid, 1'b1);
  endtask

  // Wait (bounded) for the done pulse, then confirm the run closed cleanly.
  task automatic finish_run(input string tag, input int bound);
    int k;
    k = 0;
    while ((done_cnt == done_base) && (k < bound)) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt != done_base), 1'b1);
    step();
    step();
    check({tag, "_done_once"}, done_cnt - done_base, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_valid_low"}, dout_valid, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  // Scoreboard monitor: compare each transferred beat and hold-during-stall.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1) begin
      if (dout_valid && stall_prev && stab_en) begin
        check("stall_dout_stable", dout, prev_dout);
        check("stall_addr_stable", dout_addr, prev_addr);
        check("stall_last_stable", dout_last, prev_last);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", dout, e.d);
          check("beat_addr", dout_addr, e.a);
          check("beat_last", dout_last, e.l);
        end
      end
      if (done) begin
        check("done_valid_low", dout_valid, 1'b0);
        check("done_busy_high", busy, 1'b1);
        done_cnt <= done_cnt + 1;
      end
      stall_prev <= dout_valid && !dout_ready;
      prev_dout  <= dout;
      prev_addr  <= dout_addr;
      prev_last  <= dout_last;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    beat_t b;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 2'd0;
    run_len    = 2'd0;
    dout_ready = 1'b0;
    set_bank(32'd10, 32'd11, 32'd12, 32'd13);

    // Reset state
    step();
    step();
    check("rst_dout", dout, 32'd0);
    check("rst_addr", dout_addr, 2'd0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_last", dout_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    step();

    // Full run from 0, back-to-back beats, done one cycle after the last beat
    dout_ready = 1'b1;
    run_start(2'd0, 2'd0);
    check("full_busy", busy, 1'b1);
    step(); step(); step(); step();
    check("full_done_timing", done, 1'b1);
    check("full_valid_drop", dout_valid, 1'b0);
    step();
    check("full_done_pulse", done, 1'b0);
    check("full_busy_clear", busy, 1'b0);
    finish_run("full", 10);

    // Wrapping run 3 -> 0
    run_start(2'd3, 2'd2);
    finish_run("wrap", 10);

    // Backpressure, ready pattern 0,1,0,0,1,1
    dout_ready = 1'b0;
    run_start(2'd1, 2'd3);
    dout_ready = 1'b0; step();
    dout_ready = 1'b1; step();
    dout_ready = 1'b0; step();
    dout_ready = 1'b0; step();
    dout_ready = 1'b1; step();
    dout_ready = 1'b1; step();
    finish_run("bp", 10);

    // Start while busy must be ignored
    set_bank(32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3);
    dout_ready = 1'b1;
    run_start(2'd0, 2'd0);
    start      = 1'b1;
    start_addr = 2'd2;
    run_len    = 2'd1;
    step();
    start = 1'b0;
    finish_run("busy_start", 10);

    // Reset after the first beat of a 4-beat run
    set_bank(32'd10, 32'd11, 32'd12, 32'd13);
    run_start(2'd0, 2'd0);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", dout_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dout", dout, 32'd0);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    base = done_cnt;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("midrst_no_done", done_cnt - base, 0);
    run_start(2'd2, 2'd1);
    check("midrst_restart_addr", dout_addr, 2'd2);
    finish_run("restart", 10);

    // Stall on beat 0 while bank entry 0 changes
    dout_ready = 1'b0;
    done_base  = done_cnt;
    start      = 1'b1;
    start_addr = 2'd0;
    run_len    = 2'd1;
`ifdef DRB_READER_SNAPSHOT_EN
    b.d = 32'd10;
`else
    b.d = 32'd99;
    stab_en = 1'b0;
`endif
    b.a = 2'd0;
    b.l = 1'b1;
    exp_q.push_back(b);
    step();
    start = 1'b0;
    check("snap_first_dout", dout, 32'd10);
    step();
    set_bank(32'd99, 32'd11, 32'd12, 32'd13);
    step();
    dout_ready = 1'b1;
    step();
    finish_run("snap", 10);
    stab_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_reg_bank_reader
